// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory bus arbiter.
package mem_arb_pkg;

    // Arbiter FSM state, kept as plain encoded constants.
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE   = 2'd0;
    localparam arb_state_t BUSY_I = 2'd1;
    localparam arb_state_t BUSY_D = 2'd2;
    localparam arb_state_t RESP   = 2'd3;

    // Which requester owns (or last owned) the bus.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    // Access size driven for every instruction fetch (word).
    localparam logic [2:0] FLAG_WORD = 3'b010;

    // Read data handed back when the bus never answers.
    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: memory-side bus between the arbiter (master) and the
// SoC memory/peripheral decoder (slave).
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [2:0]        flag;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              err;

    modport master (
        output valid, we, addr, wdata, flag, err,
        input  rdata, ready
    );

    modport slave (
        input  valid, we, addr, wdata, flag, err,
        output rdata, ready
    );
endinterface

// File: rtl/bus_timeout_ctr.sv
// bus_timeout_ctr: counts cycles a bus access has been waiting and raises
// expire on the last permitted cycle. LIMIT = 0 removes the counter entirely
// and holds expire low.
module bus_timeout_ctr #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    generate
        if (LIMIT == 0) begin : g_disabled
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst_n, clear, enable};
            assign expire        = 1'b0;
        end else begin : g_counter
            localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
            logic [CNT_W-1:0] count;

            // Count wait cycles; hold at the limit so the value never wraps.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (enable && !expire) begin
                    count <= count + 1'b1;
                end
            end

            assign expire = (count == CNT_W'(LIMIT - 1));
        end
    endgenerate
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between the rv32i_core instruction
// fetch port and its load/store port. One transaction at a time; the bus is
// held stable until the memory answers or the wait times out, then the owner
// gets a one-cycle ready pulse with registered data.
// Build option: define MEM_ARB_RR_EN for round-robin between the two
// requesters; without it the data port always wins a tie.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(DEFAULT_ERR_DATA)
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction fetch port
    input  logic              i_instr_req,
    input  logic [ADDR_W-1:0] i_instr_addr,
    output logic [DATA_W-1:0] o_instr_data,
    output logic              o_instr_ready,
    // load/store port
    input  logic              i_data_re,
    input  logic              i_data_we,
    input  logic [ADDR_W-1:0] i_data_addr,
    input  logic [DATA_W-1:0] i_data_wdata,
    input  logic [2:0]        i_data_flag,
    output logic [DATA_W-1:0] o_data_rdata,
    output logic              o_data_ready,
    // memory bus
    mem_bus_arbiter_if.master bus
);
    arb_state_t        state;
    arb_owner_t        grant_owner;
    logic              data_req;
    logic              any_req;
    logic              busy;
    logic              expire;
    logic [DATA_W-1:0] rsp_data;

    logic              bus_valid_q;
    logic              bus_we_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_wdata_q;
    logic [2:0]        bus_flag_q;
    logic              bus_err_q;
    logic              instr_ready_q;
    logic              data_ready_q;
    logic [DATA_W-1:0] instr_data_q;
    logic [DATA_W-1:0] data_rdata_q;

    // A load and a store raised together is treated as a store.
    assign data_req = i_data_re | i_data_we;
    assign any_req  = data_req | i_instr_req;
    assign busy     = (state == BUSY_I) || (state == BUSY_D);
    // A real answer always beats a timeout on the same edge.
    assign rsp_data = bus.ready ? bus.rdata : ERR_DATA;

    bus_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == IDLE),
        .enable (busy),
        .expire (expire)
    );

`ifdef MEM_ARB_RR_EN
    arb_owner_t rr_last;

    // Remember the last winner so the next tie goes to the other requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= OWN_D;
        end else if (state == IDLE && any_req) begin
            rr_last <= grant_owner;
        end
    end
`endif

    // Pick the requester that wins if a grant happens this cycle.
    always_comb begin
        // NOTE: assign a default before any condition so no path leaves the
        // signal unassigned; otherwise synthesis infers a latch.
        grant_owner = data_req ? OWN_D : OWN_I;
`ifdef MEM_ARB_RR_EN
        if (data_req && i_instr_req) begin
            grant_owner = (rr_last == OWN_D) ? OWN_I : OWN_D;
        end
`endif
    end

    // Transaction sequencer: grant from IDLE, wait in BUSY, pulse in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every flop here drives an output that must read 0 out of
        // reset, so all of them take the async reset, data registers included.
        if (!rst_n) begin
            state         <= IDLE;
            bus_valid_q   <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            bus_flag_q    <= '0;
            bus_err_q     <= 1'b0;
            instr_ready_q <= 1'b0;
            data_ready_q  <= 1'b0;
            instr_data_q  <= '0;
            data_rdata_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop sees the values
            // from before this edge, independent of statement order.
            instr_ready_q <= 1'b0;
            data_ready_q  <= 1'b0;
            bus_err_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        bus_valid_q <= 1'b1;
                        if (grant_owner == OWN_D) begin
                            bus_we_q    <= i_data_we;
                            bus_addr_q  <= i_data_addr;
                            bus_wdata_q <= i_data_wdata;
                            bus_flag_q  <= i_data_flag;
                            state       <= BUSY_D;
                        end else begin
                            bus_we_q    <= 1'b0;
                            bus_addr_q  <= i_instr_addr;
                            bus_wdata_q <= '0;
                            bus_flag_q  <= FLAG_WORD;
                            state       <= BUSY_I;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (bus.ready || expire) begin
                        bus_valid_q <= 1'b0;
                        bus_err_q   <= !bus.ready;
                        state       <= RESP;
                        if (state == BUSY_D) begin
                            data_ready_q <= 1'b1;
                            data_rdata_q <= rsp_data;
                        end else begin
                            instr_ready_q <= 1'b1;
                            instr_data_q  <= rsp_data;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.valid     = bus_valid_q;
    assign bus.we        = bus_we_q;
    assign bus.addr      = bus_addr_q;
    assign bus.wdata     = bus_wdata_q;
    assign bus.flag      = bus_flag_q;
    assign bus.err       = bus_err_q;
    assign o_instr_ready = instr_ready_q;
    assign o_instr_data  = instr_data_q;
    assign o_data_ready  = data_ready_q;
    assign o_data_rdata  = data_rdata_q;

endmodule
